// File: rtl/nibble_serial_comparator_if.sv
// Operand/result handshake bundle for nibble_serial_comparator.
// The slave side is the comparator; the master side is the producer/consumer.
interface nibble_serial_comparator_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic             a_grt_b;
  logic             a_less_b;
  logic             a_eq_b;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, a_grt_b, a_less_b, a_eq_b
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, a_grt_b, a_less_b, a_eq_b
  );
endinterface

// File: rtl/nibble_serial_comparator.sv
// Unsigned WIDTH-bit magnitude compare through one shared 4-bit comparator, MSB nibble first.
// Define NIBBLE_CMP_EARLY_EXIT_EN to stop at the first differing nibble (variable latency).
module nibble_serial_comparator #(
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  output logic                     busy,
  nibble_serial_comparator_if.slave bus
);
  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NIB - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMP  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  generate
    if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_bad_width
      $error("nibble_serial_comparator: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  // {greater, less}; 2'b00 means the nibbles are equal
  function automatic logic [1:0] nib_cmp(input logic [3:0] x, input logic [3:0] y);
    nib_cmp = {(x > y), (x < y)};
  endfunction

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IDX_W-1:0] idx;
  logic [1:0]       res;

  logic [3:0] a_nib;
  logic [3:0] b_nib;
  logic [1:0] nib_res;
  logic       nib_diff;
  logic       last_nib;

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIB; i++) begin
      if (idx == IDX_W'(i)) begin
        a_nib = a_q[4*i +: 4];
        b_nib = b_q[4*i +: 4];
      end
    end
    nib_res  = nib_cmp(a_nib, b_nib);
    nib_diff = |nib_res;
    last_nib = (idx == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      idx   <= '0;
      res   <= '0;
    end else if (clear) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      idx   <= '0;
      res   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            idx   <= IDX_TOP;
            res   <= '0;
            state <= CMP;
          end
        end
        CMP: begin
`ifdef NIBBLE_CMP_EARLY_EXIT_EN
          if (nib_diff) begin
            res   <= nib_res;
            state <= DONE;
          end else if (last_nib) begin
            state <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
`else
          // Only the most significant difference counts; later ones are ignored
          if (nib_diff && (res == 2'b00)) begin
            res <= nib_res;
          end
          if (last_nib) begin
            state <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
`endif
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Flags are gated by DONE so stale results never leak out between operations
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.a_grt_b   = (state == DONE) & res[1];
  assign bus.a_less_b  = (state == DONE) & res[0];
  assign bus.a_eq_b    = (state == DONE) & (res == 2'b00);
  assign busy          = (state != IDLE);
endmodule

// File: tb/tb_nibble_serial_comparator.sv
// Randomized self-checking bench for nibble_serial_comparator against an arithmetic reference model.
// Latency expectations follow NIBBLE_CMP_EARLY_EXIT_EN when it is defined for the whole compile.
module tb_nibble_serial_comparator;
  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic clk = 1'b0;
  logic rst_n;
  logic clear;
  logic busy;

  int total = 0;
  int bad   = 0;

  nibble_serial_comparator_if #(.WIDTH(WIDTH)) bus ();

  nibble_serial_comparator #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .busy  (busy),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // {gt, lt, eq} straight from unsigned arithmetic
  function automatic logic [2:0] ref_flags(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return {(x > y), (x < y), (x == y)};
  endfunction

  function automatic int ref_latency(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
`ifdef NIBBLE_CMP_EARLY_EXIT_EN
    for (int k = 1; k <= NIB; k++) begin
      if (((x >> (4 * (NIB - k))) & 15) != ((y >> (4 * (NIB - k))) & 15)) return k;
    end
    return NIB;
`else
    return NIB;
`endif
  endfunction

  function automatic logic [2:0] flags_now();
    return {bus.a_grt_b, bus.a_less_b, bus.a_eq_b};
  endfunction

  // Called #1 after a rising edge with the block idle; returns #1 after the accept edge
  task automatic start_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input int stall);
    bus.out_ready = (stall == 0);
    bus.a         = x;
    bus.b         = y;
    bus.in_valid  = 1'b1;
    chk("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input int stall);
    int n;
    logic [2:0] exp;
    n   = 0;
    exp = ref_flags(x, y);
    while (!bus.out_valid && n < NIB + 3) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 32'(n), 32'(ref_latency(x, y)));
    chk("flags", 32'(flags_now()), 32'(exp));
    chk("busy_done", 32'(busy), 32'd1);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_flags", 32'(flags_now()), 32'(exp));
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_out_valid", 32'(bus.out_valid), 32'd0);
    chk("post_in_ready", 32'(bus.in_ready), 32'd1);
    chk("post_flags", 32'(flags_now()), 32'd0);
  endtask

  task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input int stall);
    start_op(x, y, stall);
    wait_result(x, y, stall);
  endtask

  initial begin
    int n;
    logic [WIDTH-1:0] ra, rb;
    rst_n         = 1'b0;
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    #3;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_flags", 32'(flags_now()), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    run_op(16'h1234, 16'h0234, 0);
    run_op(16'h00A5, 16'h00A7, 0);
    run_op(16'hBEEF, 16'hBEEF, 0);
    run_op(16'hFFFF, 16'h0000, 0);

    // Backpressure with new operands offered throughout
    start_op(16'h4321, 16'h4322, 5);
    bus.a        = 16'h7000;
    bus.b        = 16'h6FFF;
    bus.in_valid = 1'b1;
    wait_result(16'h4321, 16'h4322, 5);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("pending_busy", 32'(busy), 32'd1);
    wait_result(16'h7000, 16'h6FFF, 0);

    // Asynchronous reset in the second CMP cycle
    start_op(16'h8000, 16'h8001, 0);
    @(posedge clk); #1;
    chk("mid_cmp_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("async_rst_flags", 32'(flags_now()), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(16'h0010, 16'h0100, 0);

    // Clear while holding a result
    start_op(16'h1234, 16'h1233, 3);
    n = 0;
    while (!bus.out_valid && n < NIB + 3) begin
      @(posedge clk); #1;
      n++;
    end
    chk("clr_done_reached", 32'(bus.out_valid), 32'd1);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    bus.out_ready = 1'b1;
    chk("clr_done_out_valid", 32'(bus.out_valid), 32'd0);
    chk("clr_done_flags", 32'(flags_now()), 32'd0);
    chk("clr_done_busy", 32'(busy), 32'd0);
    chk("clr_done_in_ready", 32'(bus.in_ready), 32'd1);

    // Clear wins over an accept in IDLE
    bus.a        = 16'h5555;
    bus.b        = 16'hAAAA;
    bus.in_valid = 1'b1;
    clear        = 1'b1;
    @(posedge clk); #1;
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    chk("clr_idle_busy", 32'(busy), 32'd0);
    chk("clr_idle_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    chk("clr_idle_busy_later", 32'(busy), 32'd0);
    chk("clr_idle_out_valid", 32'(bus.out_valid), 32'd0);
    run_op(16'h0F00, 16'h0E99, 0);

    // Randomized operand pairs, biased toward equal and single-nibble differences
    for (int t = 0; t < 200; t++) begin
      int mode;
      int pos;
      ra   = WIDTH'($urandom);
      mode = $urandom_range(0, 2);
      pos  = $urandom_range(0, NIB - 1);
      if (mode == 0) rb = WIDTH'($urandom);
      else if (mode == 1) rb = ra;
      else rb = ra ^ (WIDTH'($urandom_range(1, 15)) << (4 * pos));
      run_op(ra, rb, $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/nibble_serial_comparator.md
# nibble_serial_comparator

- Compares two unsigned WIDTH-bit operands using one shared 4-bit magnitude comparator, one nibble per clock, MSB nibble first.
- Accepts an operand pair with a valid/ready handshake, schedules the nibble comparisons, and returns a one-hot greater/less/equal result with its own valid/ready handshake.
- Sits between operand producers and wide-compare consumers when a full-width parallel comparator is too large.

## Interface

- `WIDTH`, default 16: operand width in bits.
  - Must be a multiple of 4 and at least 4.
  - Any other value is an elaboration error.
  - NIB = WIDTH/4.
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `clear` input 1: synchronous flush; returns to IDLE and drops any in-flight operation.
- `in_valid` input 1: operand pair valid.
- `in_ready` output 1: block can accept operands.
- `a` input WIDTH: operand A, unsigned.
- `b` input WIDTH: operand B, unsigned.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts the result.
- `a_grt_b` output 1: A > B.
- `a_less_b` output 1: A < B.
- `a_eq_b` output 1: A == B.
- `busy` output 1: high in CMP or DONE.

## Operation

- **States:** IDLE, CMP, DONE. State register, operand registers, nibble index and result flags are all registered.
- **IDLE:**
  - `in_ready` = 1.
  - On `in_valid && in_ready`, a and b are captured, index is set to NIB-1, and the next state is CMP.
- **CMP:** each cycle, nibble[index] of A is compared with nibble[index] of B. The compare is combinational 4-bit; the result is registered.
  - Nibbles differ: the result is decided and the next state is DONE, if EARLY_EXIT_EN is defined. Without the macro, the first difference is latched and the scan continues.
  - Nibbles equal and index == 0: the result is equal (or the latched first difference), and the next state is DONE.
  - Otherwise: index decrements and the block stays in CMP.
- **DONE:**
  - `out_valid` = 1 and exactly one flag is 1.
  - On `out_valid && out_ready`, the next state is IDLE.
- `in_ready` is 1 only in IDLE. `in_valid` outside IDLE is ignored, and the operands must not be sampled.
- Outside DONE, `out_valid` = 0 and all three flags read 0.
- Result flags and `out_valid` stay stable while `out_ready` = 0.
- **Reset (`rst_n` low, any time, including mid-CMP or DONE):**
  - Immediately: state IDLE, `out_valid` = 0, all flags 0, `busy` = 0, `in_ready` = 1.
  - The operand registers and index are cleared to 0.
- **`clear`:** same effect as reset, but at the next rising edge. It has priority over all handshakes in that cycle, including an accept in IDLE.
- **Comparison rule:** unsigned. Only the most significant differing nibble determines greater/less.

## Timing

- Accept edge is E0.
- With EARLY_EXIT_EN: `out_valid` rises after edge E0+k.
  - k = 1-based position, counted from the MSB nibble, of the first differing nibble.
  - k = NIB if the operands are equal.
- Without EARLY_EXIT_EN: `out_valid` rises after edge E0+NIB for every operand pair.
- The result handshake completes at edge Ed. The block is back in IDLE with `in_ready` = 1 after Ed.
- Minimum issue interval is k+2 cycles.
- WIDTH=4: NIB=1, latency always 1.

## Configuration

- `NIBBLE_CMP_EARLY_EXIT_EN`:
  - **Defined:** CMP exits on the first differing nibble, giving variable latency 1..NIB.
  - **Undefined:** all NIB nibbles are always scanned and the first difference is held, giving fixed latency NIB. This suits consumers needing constant timing.
  - Result values are identical in both builds.

## Test plan

1. **Early exit, A greater.** WIDTH=16, A=16'h1234, B=16'h0234, out_ready=1.
   - `a_grt_b`=1, others 0.
   - `out_valid` 1 cycle after accept with EARLY_EXIT_EN; 4 cycles after accept without it.
2. **Difference in last nibble.** A=16'h00A5, B=16'h00A7.
   - `a_less_b`=1.
   - `out_valid` 4 cycles after accept in both builds.
3. **Equal operands.** A=B=16'hBEEF.
   - `a_eq_b`=1, latency 4.
   - Then A=16'hFFFF, B=16'h0000 → `a_grt_b`=1.
4. **Result backpressure.** Hold `out_ready`=0 for 5 cycles after `out_valid` rises, driving `in_valid`=1 with new operands throughout.
   - Flags and `out_valid` stay stable; `in_ready`=0; new operands are not taken.
   - `out_ready`=1 → IDLE the next cycle; the pending operands are then accepted.
5. **Reset mid-compare.** Assert `rst_n` low in CMP on the 2nd cycle of A=16'h8000, B=16'h8001.
   - Outputs 0 and `in_ready`=1 asynchronously.
   - After release, A=16'h0010, B=16'h0100 → `a_less_b`=1.
6. **Clear with simultaneous accept.** Pulse `clear` in DONE, and separately in IDLE together with `in_valid`=1.
   - Both cases: IDLE, no result, no capture.
   - A following normal operation compares correctly.
